// File: rtl/sad_min_select.sv
// Minimum-SAD tracker for a full-search block matcher: consumes one SAD per candidate in raster
// order and reports the best motion vector with a one-cycle done pulse after the last candidate.
module sad_min_select #(
  parameter int unsigned SAD_W     = 12,
  parameter int unsigned SR        = 8,
  parameter int unsigned MV_W      = 5,
  parameter int unsigned ZERO_BIAS = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sad_valid,
  input  logic [SAD_W-1:0]       sad,
  output logic                   busy,
  output logic                   done,
  output logic [SAD_W-1:0]       best_sad,
  output logic signed [MV_W-1:0] best_mvx,
  output logic signed [MV_W-1:0] best_mvy
);

  localparam logic signed [MV_W-1:0] MvMax  = MV_W'(SR);
  localparam logic signed [MV_W-1:0] MvMin  = -MvMax;
  localparam logic [SAD_W-1:0]       ZBias  = SAD_W'(ZERO_BIAS);
  localparam logic [SAD_W-1:0]       SadMax = '1;

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e                 state_q, state_d;
  logic signed [MV_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [SAD_W-1:0]       run_min_q, run_min_d;
  logic signed [MV_W-1:0] run_mvx_q, run_mvx_d, run_mvy_q, run_mvy_d;
  logic [SAD_W-1:0]       best_sad_q, best_sad_d;
  logic signed [MV_W-1:0] best_mvx_q, best_mvx_d, best_mvy_q, best_mvy_d;
  logic                   busy_q, busy_d, done_q, done_d;

  logic             is_zero, is_first, is_last, take;
  logic [SAD_W-1:0] eff;

  always_comb begin
    is_zero  = (cx_q == '0) && (cy_q == '0);
    is_first = (cx_q == MvMin) && (cy_q == MvMin);
    is_last  = (cx_q == MvMax) && (cy_q == MvMax);
    eff      = sad;
    if (is_zero) begin
      eff = (sad > ZBias) ? (sad - ZBias) : '0;
    end
    // Index 0 always loads so an all-ones search still reports (-SR,-SR).
    take = is_first || (eff < run_min_q);
  end

  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    run_min_d  = run_min_q;
    run_mvx_d  = run_mvx_q;
    run_mvy_d  = run_mvy_q;
    best_sad_d = best_sad_q;
    best_mvx_d = best_mvx_q;
    best_mvy_d = best_mvy_q;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StActive;
      end
      StActive: begin
        if (!start && sad_valid) begin
          if (take) begin
            run_min_d = eff;
            run_mvx_d = cx_q;
            run_mvy_d = cy_q;
          end
          if (is_last) begin
            state_d    = StDone;
            best_sad_d = take ? eff  : run_min_q;
            best_mvx_d = take ? cx_q : run_mvx_q;
            best_mvy_d = take ? cy_q : run_mvy_q;
          end else if (cx_q == MvMax) begin
            cx_d = MvMin;
            cy_d = cy_q + MV_W'(1);
          end else begin
            cx_d = cx_q + MV_W'(1);
          end
        end
      end
      StDone: begin
        state_d = start ? StActive : StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Any start (idle, mid-search abort, or in the done cycle) re-arms the search.
    if (start) begin
      cx_d      = MvMin;
      cy_d      = MvMin;
      run_min_d = SadMax;
      run_mvx_d = '0;
      run_mvy_d = '0;
    end

    busy_d = (state_d == StActive);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cx_q       <= '0;
      cy_q       <= '0;
      run_min_q  <= SadMax;
      run_mvx_q  <= '0;
      run_mvy_q  <= '0;
      best_sad_q <= SadMax;
      best_mvx_q <= '0;
      best_mvy_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      run_min_q  <= run_min_d;
      run_mvx_q  <= run_mvx_d;
      run_mvy_q  <= run_mvy_d;
      best_sad_q <= best_sad_d;
      best_mvx_q <= best_mvx_d;
      best_mvy_q <= best_mvy_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign best_sad = best_sad_q;
  assign best_mvx = best_mvx_q;
  assign best_mvy = best_mvy_q;

endmodule
